// File: rtl/dcache_pkg.sv
// Shared constants and FSM state type for the direct-mapped data cache.
// Included by data_cache and dcache_storage.
package dcache_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int LINE_W      = BLOCK_BYTES * 8;
    localparam int OFFSET_W    = 4;
    localparam int WORD_W      = 2;
    localparam int MEM_ADDR_W  = 28;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        REFILL
    } state_t;

endpackage

// File: rtl/dcache_storage.sv
// Line storage: valid/dirty bits (reset) and tag/data arrays (not reset),
// one combinational read port and one whole-line write port.
module dcache_storage
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = MEM_ADDR_W - IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic              wr_dirty_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    always_ff @(posedge clock) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/data_cache.sv
// Write-back, write-allocate direct-mapped data cache: miss FSM and CPU/memory
// handshake. Define DCACHE_STATS_EN to add saturating hit_count/miss_count ports.
module data_cache
    import dcache_pkg::*;
#(
    parameter int NUM_LINES   = 8,
    parameter int BLOCK_BYTES = dcache_pkg::BLOCK_BYTES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [31:0]           cpu_address,
    input  logic [31:0]           cpu_writedata,
    input  logic [3:0]            cpu_wstrb,
    output logic [31:0]           cpu_readdata,
    output logic                  cpu_busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_BYTES*8-1:0] mem_writedata,
    input  logic [BLOCK_BYTES*8-1:0] mem_readdata,
    input  logic                  mem_busywait
`ifdef DCACHE_STATS_EN
   ,output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = MEM_ADDR_W - IDX_W;
    localparam int BW    = BLOCK_BYTES * 8;

    state_t state_q, state_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [BW-1:0]    fill_q, fill_d;

    logic [IDX_W-1:0]  req_idx, rd_idx;
    logic [TAG_W-1:0]  req_tag, rd_tag, wr_tag;
    logic [WORD_W-1:0] word;
    logic              access, hit, rd_valid, rd_dirty;
    logic              we, wr_dirty;
    logic [BW-1:0]     rd_data, wr_data, merged;

    assign req_idx = cpu_address[OFFSET_W +: IDX_W];
    assign req_tag = cpu_address[31 -: TAG_W];
    assign word    = cpu_address[OFFSET_W-1 -: WORD_W];
    assign access  = cpu_read ^ cpu_write;
    assign rd_idx  = (state_q == IDLE) ? req_idx : miss_idx_q;
    assign hit     = rd_valid && (rd_tag == req_tag);

    dcache_storage #(
        .NUM_LINES (NUM_LINES)
    ) u_storage (
        .clock      (clock),
        .reset      (reset),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (we),
        .wr_idx_i   (rd_idx),
        .wr_tag_i   (wr_tag),
        .wr_data_i  (wr_data),
        .wr_dirty_i (wr_dirty)
    );

    always_comb begin
        merged = rd_data;
        for (int b = 0; b < 4; b++) begin
            if (cpu_wstrb[b]) begin
                merged[{word, b[1:0], 3'b000} +: 8] = cpu_writedata[b*8 +: 8];
            end
        end
    end

    assign cpu_readdata  = rd_data[{word, 5'b00000} +: 32];
    assign mem_writedata = rd_data;

    always_comb begin
        state_d      = state_q;
        miss_idx_d   = miss_idx_q;
        miss_tag_d   = miss_tag_q;
        fill_d       = fill_q;
        cpu_busywait = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = {miss_tag_q, miss_idx_q};
        we           = 1'b0;
        wr_tag       = rd_tag;
        wr_data      = merged;
        wr_dirty     = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (access && hit) begin
                    we = cpu_write && (cpu_wstrb != 4'b0000);
                end else if (access) begin
                    cpu_busywait = 1'b1;
                    miss_idx_d   = req_idx;
                    miss_tag_d   = req_tag;
                    state_d      = (rd_valid && rd_dirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                cpu_busywait = 1'b1;
                mem_write    = 1'b1;
                mem_address  = {rd_tag, miss_idx_q};
                if (!mem_busywait) state_d = FETCH;
            end
            FETCH: begin
                cpu_busywait = 1'b1;
                mem_read     = 1'b1;
                if (!mem_busywait) begin
                    fill_d  = mem_readdata;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                cpu_busywait = 1'b1;
                we           = 1'b1;
                wr_tag       = miss_tag_q;
                wr_data      = fill_q;
                wr_dirty     = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset wins over any pending access or line write.
        if (reset) begin
            cpu_busywait = 1'b0;
            we           = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            fill_q     <= fill_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == IDLE && access) begin
            if (hit && hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
            if (!hit && miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache against a line-level reference cache
// model and a separate reference memory image.
module tb_data_cache;

    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read, cpu_write;
    logic [31:0]  cpu_address, cpu_writedata;
    logic [3:0]   cpu_wstrb;
    logic [31:0]  cpu_readdata;
    logic         cpu_busywait;
    logic         mem_read, mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    data_cache #(.NUM_LINES(N)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    // Reference model state
    bit           m_valid [N];
    bit           m_dirty [N];
    logic [24:0]  m_tag   [N];
    logic [127:0] m_data  [N];
    logic [127:0] ext_mem [logic [27:0]];
    logic [127:0] ref_mem [logic [27:0]];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] init_blk(input logic [27:0] a);
        return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
    endfunction

    function automatic logic [127:0] ext_get(input logic [27:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_blk(a);
    endfunction

    function automatic logic [127:0] ref_get(input logic [27:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_blk(a);
    endfunction

    // Memory side: random busy, block returned for the presented address
    always @(negedge clock) begin
        mem_busywait = ($urandom_range(0, 2) == 0);
        mem_readdata = ext_get(mem_address);
    end

    always @(posedge clock) begin
        if (mem_write && !mem_busywait) ext_mem[mem_address] = mem_writedata;
    end

    task automatic op(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input string nm);
        logic [2:0]   idx;
        logic [24:0]  tg;
        int           w;
        bit           acc, hit, exp_wb, seen_wb, seen_rd, both;
        logic [27:0]  wb_a, obs_wb_a, obs_rd_a;
        logic [127:0] wb_d, obs_wb_d;
        int           cyc;
        idx = a[6:4];
        tg  = a[31:7];
        w   = int'(a[3:2]);
        acc = rd ^ wr;
        hit = m_valid[idx] && (m_tag[idx] == tg);
        seen_wb = 0; seen_rd = 0; both = 0; cyc = 0;
        obs_wb_a = '0; obs_rd_a = '0; obs_wb_d = '0;
        @(negedge clock);
        cpu_read = rd; cpu_write = wr; cpu_address = a;
        cpu_writedata = wd; cpu_wstrb = st;
        #1;
        if (acc && !hit) begin
            check({nm, " miss_busy"}, cpu_busywait, 1'b1);
            exp_wb = m_valid[idx] && m_dirty[idx];
            wb_a   = {m_tag[idx], idx};
            wb_d   = m_data[idx];
            while (cpu_busywait && cyc < 200) begin
                @(negedge clock);
                #1;
                cyc++;
                if (mem_write && !seen_wb) begin
                    seen_wb = 1; obs_wb_a = mem_address; obs_wb_d = mem_writedata;
                end
                if (mem_read) begin
                    seen_rd = 1; obs_rd_a = mem_address;
                end
                if (mem_read && mem_write) both = 1;
            end
            check({nm, " miss_timeout"}, cpu_busywait, 1'b0);
            check({nm, " wb_seen"}, seen_wb, exp_wb);
            if (exp_wb) begin
                check({nm, " wb_addr"}, obs_wb_a, wb_a);
                check({nm, " wb_data"}, obs_wb_d, wb_d);
                ref_mem[wb_a] = wb_d;
            end
            check({nm, " fetch_seen"}, seen_rd, 1'b1);
            check({nm, " fetch_addr"}, obs_rd_a, {tg, idx});
            check({nm, " rd_wr_overlap"}, both, 1'b0);
            m_data[idx]  = ref_get({tg, idx});
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx]   = tg;
        end
        check({nm, " busy"}, cpu_busywait, 1'b0);
        if (acc && rd) check({nm, " rdata"}, cpu_readdata, m_data[idx][w*32 +: 32]);
        if (acc && wr && st != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) m_data[idx][w*32 + b*8 +: 8] = wd[b*8 +: 8];
            m_dirty[idx] = 1;
        end
        @(posedge clock);
        #1;
        if (!acc) begin
            check({nm, " noacc_mem"}, {mem_read, mem_write}, 2'b00);
        end
    endtask

    task automatic rand_op(input string nm);
        int          k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4)
            | ($urandom_range(0, 3) << 2);
        if (k == 0)     op(0, 0, a, $urandom, 4'($urandom), nm);
        else if (k == 1) op(1, 1, a, $urandom, 4'($urandom), nm);
        else if (k < 6) op(1, 0, a, $urandom, 4'($urandom), nm);
        else            op(0, 1, a, $urandom, 4'($urandom), nm);
    endtask

    task automatic reset_mid_fetch();
        logic [2:0]  idx;
        logic [31:0] a;
        int          cyc;
        idx = 3'($urandom_range(0, 7));
        a   = (32'd5 << 7) | (32'(idx) << 4);
        cyc = 0;
        @(negedge clock);
        cpu_read = 1; cpu_write = 0; cpu_address = a;
        #1;
        while (!mem_read && cyc < 200) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check("rst fetch_reached", mem_read, 1'b1);
        if (m_valid[idx] && m_dirty[idx]) ref_mem[{m_tag[idx], idx}] = m_data[idx];
        reset = 1;
        #1;
        check("rst busy_during_reset", cpu_busywait, 1'b0);
        @(negedge clock);
        #1;
        check("rst mem_req_dropped", {mem_read, mem_write}, 2'b00);
        reset = 0;
        cpu_read = 0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
    endtask

    initial begin
        reset = 1;
        cpu_read = 1; cpu_write = 0; cpu_address = 32'h40;
        cpu_writedata = '0; cpu_wstrb = '0;
        repeat (2) @(negedge clock);
        #1;
        check("reset busy", cpu_busywait, 1'b0);
        check("reset mem_req", {mem_read, mem_write}, 2'b00);
        @(negedge clock);
        reset = 0;
        cpu_read = 0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end

        op(1, 0, 32'h40, 32'h0, 4'h0, "rd40");
        op(0, 1, 32'h44, 32'hDEADBEEF, 4'hF, "wr44");
        op(1, 0, 32'h44, 32'h0, 4'h0, "rd44");
        op(0, 1, 32'h48, 32'h11223344, 4'hF, "wr48");
        op(0, 1, 32'h48, 32'h0000AB00, 4'h2, "wr48_strb");
        op(1, 0, 32'h48, 32'h0, 4'h0, "rd48");
        op(1, 0, 32'hC0, 32'h0, 4'h0, "rdC0_evict");
        op(0, 1, 32'hC4, 32'hFFFFFFFF, 4'h0, "wrC4_nostrb");
        op(1, 0, 32'hC4, 32'h0, 4'h0, "rdC4");
        op(1, 1, 32'hC4, 32'h12345678, 4'hF, "both_hi");
        op(1, 0, 32'hC4, 32'h0, 4'h0, "rdC4_after_both");
        op(0, 0, 32'h1C0, 32'h0, 4'hF, "both_lo");

        for (int i = 0; i < 300; i++) rand_op("rand");

        reset_mid_fetch();
        op(1, 0, 32'h44, 32'h0, 4'h0, "rd44_after_rst");
        for (int i = 0; i < 60; i++) rand_op("rand2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
